// File: rtl/framed_parity_checker_pkg.sv
// Shared types and helpers for the framed parity checker and its status counters.
package framed_parity_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/framed_parity_checker_sat_counter.sv
// Saturating event counter; a clear that coincides with an event leaves a count of one.
module sat_counter
    import framed_parity_checker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && (count_q != MAX_COUNT)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/framed_parity_checker.sv
// Serial checker for LSB-first frames of DATA_BITS data bits plus one parity bit,
// with registered per-frame results and saturating error accounting.
module framed_parity_checker
    import framed_parity_checker_pkg::*;
#(
    parameter int   DATA_BITS  = 8,
    parameter logic ODD_PARITY = PAR_EVEN,
    parameter int   ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 in_sof,
    input  logic                 clr_err,
    output logic                 par_even,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic                 frame_abort,
    output logic [DATA_BITS-1:0] data_out,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sticky,
    output logic [1:0]           state_dbg
);

    // Handshake: a bit is consumed on every rising edge where in_valid is 1;
    // there is no back-pressure, so the upstream never waits.

    localparam int                CNT_W    = clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_BITS - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_out_q;
    logic                   par_even_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic                   frame_ok_q;
    logic                   frame_abort_q;
    logic                   err_sticky_q;

    logic accept_sof;
    logic abort_evt;
    logic parity_evt;
    logic frame_ok_d;
    logic err_inc;

    assign accept_sof = in_valid & in_sof;
    assign abort_evt  = accept_sof & (state_q != ST_IDLE);
    assign parity_evt = in_valid & ~in_sof & (state_q == ST_PARITY);
    // par_even_q ^ in_bit is 1 when the total ones count including parity is even.
    assign frame_ok_d = (par_even_q ^ in_bit) ^ ODD_PARITY;
    assign err_inc    = abort_evt | (parity_evt & ~frame_ok_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            par_even_q    <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_abort_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;

            if (clr_err) begin
                err_sticky_q <= err_inc;
            end else if (err_inc) begin
                err_sticky_q <= 1'b1;
            end

            // A start-of-frame always wins: it either opens a frame or restarts one.
            if (accept_sof) begin
                frame_abort_q <= abort_evt;
                shift_q[0]    <= in_bit;
                par_even_q    <= ~in_bit;
                busy_q        <= 1'b1;
                if (DATA_BITS == 1) begin
                    state_q <= ST_PARITY;
                    cnt_q   <= '0;
                end else begin
                    state_q <= ST_DATA;
                    cnt_q   <= CNT_W'(1);
                end
            end else if (in_valid) begin
                case (state_q)
                    ST_DATA: begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shift_q[i] <= in_bit;
                            end
                        end
                        par_even_q <= par_even_q ^ in_bit;
                        if (cnt_q == LAST_IDX) begin
                            state_q <= ST_PARITY;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        frame_done_q <= 1'b1;
                        frame_ok_q   <= frame_ok_d;
                        data_out_q   <= shift_q;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        par_even_q   <= 1'b1;
                        cnt_q        <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH(ERR_CNT_W)
    ) u_err_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (err_inc),
        .clr_i  (clr_err),
        .count_o(err_cnt)
    );

    assign par_even    = par_even_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign frame_abort = frame_abort_q;
    assign data_out    = data_out_q;
    assign err_sticky  = err_sticky_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_framed_parity_checker.sv
// Bench for framed_parity_checker: even- and odd-mode instances share one random
// stimulus stream and are scored against a frame-level model.
module tb_framed_parity_checker;

    localparam int DB = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_sof = 1'b0;
    logic clr_err = 1'b0;

    logic          e_par_even, e_busy, e_done, e_ok, e_abort, e_sticky;
    logic [DB-1:0] e_data;
    logic [CW-1:0] e_cnt;
    logic [1:0]    e_state;
    logic          o_par_even, o_busy, o_done, o_ok, o_abort, o_sticky;
    logic [DB-1:0] o_data;
    logic [CW-1:0] o_cnt;
    logic [1:0]    o_state;

    framed_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b0), .ERR_CNT_W(CW)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .clr_err(clr_err), .par_even(e_par_even), .busy(e_busy), .frame_done(e_done),
        .frame_ok(e_ok), .frame_abort(e_abort), .data_out(e_data), .err_cnt(e_cnt),
        .err_sticky(e_sticky), .state_dbg(e_state)
    );

    framed_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b1), .ERR_CNT_W(CW)) dut_o (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .clr_err(clr_err), .par_even(o_par_even), .busy(o_busy), .frame_done(o_done),
        .frame_ok(o_ok), .frame_abort(o_abort), .data_out(o_data), .err_cnt(o_cnt),
        .err_sticky(o_sticky), .state_dbg(o_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference model: bits of the open frame, per-mode counters.
    bit            fb_q[$];
    int            mcnt[2];
    bit            msticky[2];
    bit            mlast_ok[2];
    logic [DB-1:0] mlast_data;
    logic          exp_done;
    logic          exp_abort;
    logic [18:0]   exp_e_q[$];
    logic [18:0]   exp_o_q[$];

    function automatic bit fb_even();
        int n;
        n = 0;
        foreach (fb_q[i]) n += int'(fb_q[i]);
        return (n % 2) == 0;
    endfunction

    task automatic model_reset();
        fb_q.delete();
        exp_e_q.delete();
        exp_o_q.delete();
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0;
            msticky[m] = 1'b0;
            mlast_ok[m] = 1'b0;
        end
        mlast_data = '0;
        exp_done = 1'b0;
        exp_abort = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic s, input logic c);
        bit fin, abrt, ev;
        bit ok[2];
        int ones;
        logic [DB-1:0] d;
        logic [18:0] x;
        fin = 1'b0;
        abrt = 1'b0;
        ones = 0;
        d = '0;
        if (v) begin
            if (s) begin
                abrt = fb_q.size() > 0;
                fb_q.delete();
                fb_q.push_back(b);
            end else if (fb_q.size() > 0) begin
                fb_q.push_back(b);
                if (fb_q.size() == DB + 1) begin
                    fin = 1'b1;
                    foreach (fb_q[i]) begin
                        ones += int'(fb_q[i]);
                        if (i < DB) d = d | (DB'(fb_q[i]) << i);
                    end
                    fb_q.delete();
                end
            end
        end
        ok[0] = (ones % 2) == 0;
        ok[1] = (ones % 2) == 1;
        if (fin) mlast_data = d;
        for (int m = 0; m < 2; m++) begin
            ev = abrt | (fin & ~ok[m]);
            if (c) begin
                mcnt[m] = ev ? 1 : 0;
                msticky[m] = ev;
            end else if (ev) begin
                if (mcnt[m] < (1 << CW) - 1) mcnt[m]++;
                msticky[m] = 1'b1;
            end
            if (fin) mlast_ok[m] = ok[m];
            if (fin || abrt) begin
                x = {abrt, mlast_ok[m], mlast_data, CW'(mcnt[m]), msticky[m]};
                if (m == 0) exp_e_q.push_back(x);
                else exp_o_q.push_back(x);
            end
        end
        exp_done = fin;
        exp_abort = abrt;
    endtask

    // Inputs change just after the falling edge; the DUT samples on the next rising edge.
    task automatic send_bit(input logic v, input logic b, input logic s, input logic c);
        @(negedge clk);
        #1;
        in_valid = v;
        in_bit = b;
        in_sof = s;
        clr_err = c;
        model_step(v, b, s, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input int gap_pct,
                              input logic clr_at_par);
        for (int i = 0; i <= DB; i++) begin
            while (int'($urandom_range(99)) < gap_pct)
                send_bit(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
            send_bit(1'b1, (i < DB) ? d[i] : p, i == 0, (i == DB) ? clr_at_par : 1'b0);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_par_even_e", e_par_even, 1);
        check("rst_busy_e", e_busy, 0);
        check("rst_done_e", e_done, 0);
        check("rst_ok_e", e_ok, 0);
        check("rst_abort_e", e_abort, 0);
        check("rst_data_e", e_data, 0);
        check("rst_cnt_e", e_cnt, 0);
        check("rst_sticky_e", e_sticky, 0);
        check("rst_par_even_o", o_par_even, 1);
        check("rst_busy_o", o_busy, 0);
        check("rst_done_o", o_done, 0);
        check("rst_abort_o", o_abort, 0);
        check("rst_data_o", o_data, 0);
        check("rst_cnt_o", o_cnt, 0);
        check("rst_sticky_o", o_sticky, 0);
    endtask

    // Monitor: per-cycle status against the model, plus scoreboard pops on each result pulse.
    always @(negedge clk) begin
        logic [18:0] x;
        if (rst) begin
            check("done_e", e_done, exp_done);
            check("done_o", o_done, exp_done);
            check("abort_e", e_abort, exp_abort);
            check("abort_o", o_abort, exp_abort);
            check("par_even_e", e_par_even, fb_even());
            check("par_even_o", o_par_even, fb_even());
            check("busy_e", e_busy, fb_q.size() > 0);
            check("busy_o", o_busy, fb_q.size() > 0);
            check("state_busy_e", e_state != 2'd0, fb_q.size() > 0);
            check("cnt_e", e_cnt, mcnt[0]);
            check("cnt_o", o_cnt, mcnt[1]);
            check("sticky_e", e_sticky, msticky[0]);
            check("sticky_o", o_sticky, msticky[1]);
            if (e_done || e_abort) begin
                if (exp_e_q.size() == 0) check("unexpected_e", 1, 0);
                else begin
                    x = exp_e_q.pop_front();
                    check("frame_e", {e_abort, e_ok, e_data, e_cnt, e_sticky}, x);
                end
            end
            if (o_done || o_abort) begin
                if (exp_o_q.size() == 0) check("unexpected_o", 1, 0);
                else begin
                    x = exp_o_q.pop_front();
                    check("frame_o", {o_abort, o_ok, o_data, o_cnt, o_sticky}, x);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals();
        rst = 1'b1;

        // Directed frames with fixed expected results.
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        idle(1);
        check("a5_done", e_done, 1);
        check("a5_data", e_data, 8'hA5);
        check("a5_ok_e", e_ok, 1);
        check("a5_ok_o", o_ok, 0);
        check("a5_cnt_e", e_cnt, 0);

        send_frame(8'h01, 1'b0, 0, 1'b0);
        idle(1);
        check("x01_ok_e", e_ok, 0);
        check("x01_ok_o", o_ok, 1);
        check("x01_cnt_e", e_cnt, 1);
        check("x01_sticky_e", e_sticky, 1);
        check("x01_par_even_idle", e_par_even, 1);

        send_bit(1'b1, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 0, 1'b0);
        idle(1);
        check("ff_ok_e", e_ok, 1);
        check("ff_data", e_data, 8'hFF);
        check("ff_cnt_e", e_cnt, 2);
        check("ff_cnt_o", o_cnt, 3);

        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 40, 1'b0);
        idle(1);
        check("x3c_ok_e", e_ok, 1);
        check("x3c_data", e_data, 8'h3C);
        check("x3c_cnt_e", e_cnt, 2);
        check("x3c_cnt_o", o_cnt, 4);

        // Random traffic: stray bits, partial frames cut by a new sof, clears, gaps.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(5) == 0) begin
                int n;
                n = int'($urandom_range(1, DB));
                for (int i = 0; i < n; i++) send_bit(1'b1, 1'($urandom_range(1)), i == 0, 1'b0);
            end else if ($urandom_range(3) == 0) begin
                send_bit(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
            end
            if ($urandom_range(7) == 0) send_bit(1'b0, 1'b0, 1'b0, 1'b1);
            send_frame(8'($urandom_range(255)), 1'($urandom_range(1)), int'($urandom_range(30)),
                       $urandom_range(3) == 0);
        end

        for (int k = 0; k < 260; k++) send_frame(8'h01, 1'b0, 0, 1'b0);
        idle(1);
        check("sat_cnt_e", e_cnt, 255);

        send_frame(8'h01, 1'b0, 0, 1'b1);
        idle(1);
        check("clr_evt_cnt_e", e_cnt, 1);
        check("clr_evt_sticky_e", e_sticky, 1);
        check("clr_evt_cnt_o", o_cnt, 0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("clr_only_cnt_e", e_cnt, 0);
        check("clr_only_sticky_e", e_sticky, 0);

        // Asynchronous reset in the middle of a frame.
        send_bit(1'b1, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        send_frame(8'h96, 1'b1, 0, 1'b0);
        idle(1);
        check("post_rst_ok_e", e_ok, 0);
        check("post_rst_ok_o", o_ok, 1);
        check("post_rst_data", e_data, 8'h96);
        check("post_rst_cnt_e", e_cnt, 1);

        idle(3);
        check("pending_e", exp_e_q.size(), 0);
        check("pending_o", exp_o_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/framed_parity_checker.md
Name: framed_parity_checker

Overview:
- Serial parity checker for framed bit streams.
- Each frame is DATA_BITS data bits followed by one parity bit; the block checks the parity bit against the selected mode (even/odd).
- Per frame it delivers the frame data, a registered pass/fail result and abort indication, a running-parity status and a saturating error counter.
- Sits behind a serial deserialiser/line receiver; results feed the status/CSR block.

Parameters:
- DATA_BITS, 8, data bits per frame (>=1).
- ODD_PARITY, 0, 0 = frame valid when total ones (data+parity) is even; 1 = when odd.
- ERR_CNT_W, 8, width of saturating error counter (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  in_bit qualifier; bit accepted when 1.
- in_bit  in  1  serial bit, LSB-first data then parity.
- in_sof  in  1  start of frame; meaningful only with in_valid.
- clr_err  in  1  synchronous clear of err_cnt and err_sticky.
- par_even  out  1  1 when count of ones accepted so far in current frame is even.
- busy  out  1  1 while in DATA or PARITY state.
- frame_done  out  1  one-cycle pulse: frame completed (parity bit accepted).
- frame_ok  out  1  parity result of last completed frame; valid with frame_done, held until next.
- frame_abort  out  1  one-cycle pulse: frame aborted by in_sof before completion.
- data_out  out  DATA_BITS  data of last completed frame, bit0 = first received; updated with frame_done only.
- err_cnt  out  ERR_CNT_W  saturating count of parity failures plus aborts.
- err_sticky  out  1  set on any failure/abort until clr_err.

Behaviour:
- Reset (rst=0, async): state IDLE, bit counter 0, par_even=1, busy=0, frame_done=0, frame_ok=0, frame_abort=0, data_out=0, err_cnt=0, err_sticky=0. All outputs are registered.
- States: IDLE, DATA, PARITY. in_valid=0 in any state: no state change, no output change except pulses returning to 0.
- IDLE:
  - in_valid & in_sof: bit is data bit 0; go DATA (or PARITY if DATA_BITS=1); par_even = ~in_bit.
  - in_valid & ~in_sof: bit discarded.
- DATA:
  - Each accepted bit is shifted into the shift register at its index and toggles par_even when 1.
  - After the DATA_BITS-th data bit, go PARITY.
- PARITY, accepted bit:
  - ok = (ones parity incl. parity bit) matches mode.
  - Next cycle: frame_done=1, frame_ok=ok, data_out=shift register.
  - State returns to IDLE, par_even=1.
  - Latency: frame_done is 1 cycle after the parity bit is accepted.
- Back-to-back: in_sof on the cycle directly after the parity bit starts the next frame; no gap required.
- in_sof with in_valid during DATA or PARITY:
  - Abort: next cycle frame_abort=1, frame_done=0, data_out/frame_ok unchanged.
  - The same bit is data bit 0 of a new frame; counter and par_even restart from that bit.
- Error accounting: increment err_cnt on (frame_done & ~frame_ok) or frame_abort. Saturates at 2^ERR_CNT_W-1; no wrap. err_sticky is set by the same events.
- clr_err coinciding with an increment event: err_cnt=1, err_sticky=1 (event not lost). clr_err alone: both 0.
- Reset mid-frame: frame discarded silently, no abort pulse, no count.
- Bit counter width: clog2(DATA_BITS+1); never exceeds DATA_BITS-1 in DATA.

Decomposition:
- Shared package: state enum (IDLE/DATA/PARITY), parity-mode constants (EVEN=0, ODD=1), clog2 helper.
- Sub-module sat_counter (WIDTH param; inc, clr inputs with clr+inc → 1) for err_cnt; reusable by other status blocks.

Test Plan (DATA_BITS=8, ERR_CNT_W=8):
- ODD_PARITY=0: sof, data 0xA5 LSB-first, parity 0 → frame_done 1 cycle after parity, frame_ok=1, data_out=0xA5, err_cnt=0.
- ODD_PARITY=0: data 0x01, parity 0 → frame_ok=0, err_cnt=1, err_sticky=1; par_even traces 1,0,0,...,0 then 1 in IDLE. ODD_PARITY=1, same stimulus → frame_ok=1.
- Abort: sof, 4 data bits, sof + 8 bits 0xFF + parity 0 → frame_abort pulse at 5th accepted bit+1; then frame_done, frame_ok=1, data_out=0xFF, err_cnt=1.
- Gaps/idle: in_valid toggled randomly mid-frame, and valid bits without sof in IDLE → ignored bits do not affect result; 0x3C frame passes.
- Saturation/clear: 260 bad frames → err_cnt=255. clr_err in same cycle as a failure → err_cnt=1. clr_err alone → 0.
- Async reset asserted mid-DATA → all outputs at reset values immediately, no frame_abort. A subsequent sof frame is checked correctly.
